// File: rtl/div_pkg.sv
// Shared types, sizing constants and the magnitude helper for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 40;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Caller sign-extends to 64 bits and truncates the result back to its width,
  // so the most negative operand maps to its correct unsigned magnitude.
  function automatic logic [63:0] abs_w(input logic signed [63:0] v);
    return v[63] ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep or restore the partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;

  assign w_shift = {i_rem, i_msb};
  assign o_q_bit = (w_shift >= {1'b0, i_divisor});
  // When the trial succeeds the difference is below the divisor, so the low bits suffice.
  assign w_sub   = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = o_q_bit ? w_sub : w_shift[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed restoring divider with independent A/B operand handshakes.
// Optional early-out for small quotients is enabled by defining DIV_EARLY_OUT_EN.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_a_valid,
  input  logic [WIDTH-1:0]   div_a_data,
  output logic               div_a_ready,
  input  logic               div_b_valid,
  input  logic [WIDTH-1:0]   div_b_data,
  output logic               div_b_ready,
  output logic               div_p_valid,
  output logic [2*WIDTH-1:0] div_p_data
);

  div_state_t r_state;
  div_state_t w_state_next;

  logic               r_a_held;
  logic               r_b_held;
  logic [WIDTH-1:0]   r_a_data;
  logic [WIDTH-1:0]   r_b_data;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p_data;

  logic             w_a_fire;
  logic             w_b_fire;
  logic             w_start;
  logic             w_early;
  logic             w_last_step;
  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  assign div_a_ready = resetn && (r_state == DIV_IDLE) && !r_a_held;
  assign div_b_ready = resetn && (r_state == DIV_IDLE) && !r_b_held;
  assign div_p_data  = r_p_data;

  assign w_a_fire = div_a_valid && div_a_ready;
  assign w_b_fire = div_b_valid && div_b_ready;

  // An operand is either already held or transferring on this very edge.
  assign w_dividend = r_a_held ? r_a_data : div_a_data;
  assign w_divisor  = r_b_held ? r_b_data : div_b_data;
  assign w_start    = (r_state == DIV_IDLE) && (r_a_held || w_a_fire) && (r_b_held || w_b_fire);

  assign w_abs_a = WIDTH'(abs_w(64'(signed'(w_dividend))));
  assign w_abs_b = WIDTH'(abs_w(64'(signed'(w_divisor))));

`ifdef DIV_EARLY_OUT_EN
  // A zero divisor always runs the full sequence to produce the all-ones quotient.
  assign w_early = (w_divisor != '0) && ((w_abs_b > w_abs_a) || (w_dividend == '0));
`else
  assign w_early = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_msb    (r_dvd[WIDTH-1]),
    .i_divisor(r_dvs),
    .o_rem    (w_rem_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_last_step = (r_state == DIV_CALC) && (r_cnt == CNT_W'(1));
  assign w_q_raw     = {r_dvd[WIDTH-2:0], w_q_bit};
  assign w_q_final   = r_q_neg ? -w_q_raw : w_q_raw;
  assign w_r_final   = r_r_neg ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    div_p_valid  = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (w_start) begin
          w_state_next = w_early ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (w_last_step) begin
          w_state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        div_p_valid  = 1'b1;
        w_state_next = DIV_IDLE;
      end
      default: begin
        w_state_next = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a_held <= 1'b0;
      r_b_held <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_cnt    <= '0;
      r_p_data <= '0;
    end else begin
      if (w_a_fire) begin
        r_a_data <= div_a_data;
        r_a_held <= 1'b1;
      end
      if (w_b_fire) begin
        r_b_data <= div_b_data;
        r_b_held <= 1'b1;
      end
      if (r_state == DIV_DONE) begin
        r_a_held <= 1'b0;
        r_b_held <= 1'b0;
      end

      if (w_start) begin
        r_dvd   <= w_abs_a;
        r_dvs   <= w_abs_b;
        r_q_neg <= w_dividend[WIDTH-1] ^ w_divisor[WIDTH-1];
        r_r_neg <= w_dividend[WIDTH-1];
        r_cnt   <= CNT_W'(WIDTH);
        r_rem   <= '0;
        if (w_early) begin
          r_p_data <= {{WIDTH{1'b0}}, w_dividend};
        end
      end else if (r_state == DIV_CALC) begin
        // Quotient bits shift into the vacated low end of the dividend register.
        r_dvd <= w_q_raw;
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last_step) begin
          r_p_data <= {w_q_final, w_r_final};
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed table-driven bench for iter_divider plus split-arrival and mid-CALC reset sequences.
`timescale 1ns/1ps
module tb_iter_divider;

  localparam int W = 40;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           div_a_valid = 1'b0;
  logic [W-1:0]   div_a_data = '0;
  logic           div_a_ready;
  logic           div_b_valid = 1'b0;
  logic [W-1:0]   div_b_data = '0;
  logic           div_b_ready;
  logic           div_p_valid;
  logic [2*W-1:0] div_p_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iter_divider dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_a_valid(div_a_valid),
    .div_a_data (div_a_data),
    .div_a_ready(div_a_ready),
    .div_b_valid(div_b_valid),
    .div_b_data (div_b_data),
    .div_b_ready(div_b_ready),
    .div_p_valid(div_p_valid),
    .div_p_data (div_p_data)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           early;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Waits for p_valid starting right after the capture edge; returns posedges counted from capture.
  task automatic wait_result(output int lat);
    lat = 1;
    while (div_p_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    check($sformatf("%s.a_ready_idle", tag), 80'(div_a_ready), 80'(1));
    check($sformatf("%s.b_ready_idle", tag), 80'(div_b_ready), 80'(1));
    div_a_valid = 1'b1;
    div_a_data  = a;
    div_b_valid = 1'b1;
    div_b_data  = b;
    @(posedge clk);
    #1;
    div_a_valid = 1'b0;
    div_b_valid = 1'b0;
    check($sformatf("%s.a_ready_drop", tag), 80'(div_a_ready), 80'(0));
    check($sformatf("%s.b_ready_drop", tag), 80'(div_b_ready), 80'(0));
    wait_result(lat);
    check($sformatf("%s.latency", tag), 80'(lat), 80'(exp_lat));
    check($sformatf("%s.quotient", tag), 80'(div_p_data[2*W-1:W]), 80'(q));
    check($sformatf("%s.remainder", tag), 80'(div_p_data[W-1:0]), 80'(r));
    $display("txn %s a=%h b=%h q=%h r=%h lat=%0d", tag, a, b,
             div_p_data[2*W-1:W], div_p_data[W-1:0], lat);
    @(posedge clk);
    #1;
    check($sformatf("%s.pulse_end", tag), 80'(div_p_valid), 80'(0));
    check($sformatf("%s.ready_back", tag), 80'(div_a_ready & div_b_ready), 80'(1));
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{40'd7,            40'd2,            40'd3,            40'd1,            1'b0};
    vecs[1]  = '{40'hFF_FFFF_FFF9, 40'd2,            40'hFF_FFFF_FFFD, 40'hFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{40'd7,            40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFD, 40'd1,            1'b0};
    vecs[3]  = '{40'hFF_FFFF_FFF9, 40'hFF_FFFF_FFFE, 40'd3,            40'hFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{40'h00_FFFF_FFFF, 40'd1,            40'h00_FFFF_FFFF, 40'd0,            1'b0};
    vecs[5]  = '{40'd5,            40'd0,            40'hFF_FFFF_FFFF, 40'd5,            1'b0};
    vecs[6]  = '{40'hFF_FFFF_FFFB, 40'd0,            40'd1,            40'hFF_FFFF_FFFB, 1'b0};
    vecs[7]  = '{40'd3,            40'd10,           40'd0,            40'd3,            1'b1};
    vecs[8]  = '{40'h80_0000_0000, 40'hFF_FFFF_FFFF, 40'h80_0000_0000, 40'd0,            1'b0};
    vecs[9]  = '{40'd0,            40'd5,            40'd0,            40'd0,            1'b1};
    vecs[10] = '{40'd100,          40'd7,            40'd14,           40'd2,            1'b0};
    vecs[11] = '{40'h7F_FFFF_FFFF, 40'h10,           40'h07_FFFF_FFFF, 40'hF,            1'b0};
    vecs[12] = '{40'hFF_FFFF_FFFD, 40'd10,           40'd0,            40'hFF_FFFF_FFFD, 1'b1};
    vecs[13] = '{40'd6,            40'd6,            40'd1,            40'd0,            1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.a_ready", 80'(div_a_ready), 80'(0));
    check("reset.b_ready", 80'(div_b_ready), 80'(0));
    check("reset.p_valid", 80'(div_p_valid), 80'(0));
    check("reset.p_data", 80'(div_p_data), 80'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_reset.readys", 80'(div_a_ready & div_b_ready), 80'(1));

    // Table vectors, issued back-to-back
    for (int i = 0; i < 14; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               exp_latency(vecs[i].early), $sformatf("vec%0d", i));
    end

    // Result holds while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold.p_data", 80'(div_p_data), {vecs[13].q, vecs[13].r});

    // Split arrival: A at cycle 0, B at cycle 3; A stays valid with junk data meanwhile
    @(negedge clk);
    div_a_valid = 1'b1;
    div_a_data  = 40'd20;
    @(posedge clk);
    #1;
    check("split.a_ready_low", 80'(div_a_ready), 80'(0));
    check("split.b_ready_high", 80'(div_b_ready), 80'(1));
    div_a_data = 40'd999;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("split.no_start", 80'(div_a_ready), 80'(0));
    check("split.no_pvalid", 80'(div_p_valid), 80'(0));
    div_b_valid = 1'b1;
    div_b_data  = 40'd6;
    @(posedge clk);
    #1;
    div_a_valid = 1'b0;
    div_b_valid = 1'b0;
    check("split.b_ready_drop", 80'(div_b_ready), 80'(0));
    wait_result(lat);
    check("split.latency", 80'(lat), 80'(W + 1));
    check("split.quotient", 80'(div_p_data[2*W-1:W]), 80'(3));
    check("split.remainder", 80'(div_p_data[W-1:0]), 80'(2));
    $display("txn split a=20 b=6 q=%h r=%h lat=%0d", div_p_data[2*W-1:W], div_p_data[W-1:0], lat);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC
    @(negedge clk);
    div_a_valid = 1'b1;
    div_a_data  = 40'd1000;
    div_b_valid = 1'b1;
    div_b_data  = 40'd7;
    @(posedge clk);
    #1;
    div_a_valid = 1'b0;
    div_b_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset.p_valid", 80'(div_p_valid), 80'(0));
    check("midreset.p_data", 80'(div_p_data), 80'(0));
    check("midreset.readys_low", 80'(div_a_ready | div_b_ready), 80'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midreset.readys_high", 80'(div_a_ready & div_b_ready), 80'(1));
    seen = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (div_p_valid === 1'b1) seen = 1'b1;
    end
    check("midreset.no_pvalid", 80'(seen), 80'(0));
    $display("txn midreset a=1000 b=7 discarded p_valid_seen=%0d", seen);
    run_pair(40'd9, 40'd3, 40'd3, 40'd0, W + 1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
